// File: rtl/sl28_pkg.sv
// Shared definitions for the sl28 CPLD CSR blocks.
// Holds the interrupt controller's register map.
package sl28_pkg;

  localparam logic [4:0] INTC_BASE   = 5'h1c;
  localparam logic [4:0] INTC_STATUS = 5'd0;
  localparam logic [4:0] INTC_ENABLE = 5'd1;
  localparam logic [4:0] INTC_MODE   = 5'd2;
  localparam logic [4:0] INTC_RAW    = 5'd3;

endpackage

// File: rtl/irq_sync.sv
// Per-source input synchroniser.
// A 3-flop chain: s2 is the synchronised level, s2 & ~s3 is a rising-edge event.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic level,
  output logic edge_det
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level    = s2;
  assign edge_det = s2 & ~s3;

endmodule

// File: rtl/intc.sv
// Interrupt controller: latches up to eight synchronised sources as level or edge
// events, masks them per source and drives one registered interrupt request.
module intc
  import sl28_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = INTC_BASE,
  parameter int         NUM_IRQS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_IRQS-1:0] irq_in,
  output logic                irq_out
);

  logic [NUM_IRQS-1:0] level, edge_evt;
  logic [NUM_IRQS-1:0] pending, pending_nxt;
  logic [NUM_IRQS-1:0] enable, mode;
  logic [NUM_IRQS-1:0] wdata, w1c, mode_chg;
  logic                sel_status, sel_enable, sel_mode, sel_raw;
  logic [7:0]          pend_rd, en_rd, mode_rd, raw_rd;

  for (genvar i = 0; i < NUM_IRQS; i++) begin : g_sync
    irq_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq_in[i]),
      .level    (level[i]),
      .edge_det (edge_evt[i])
    );
  end

  assign sel_status = (csr_a == BASE_ADDR + INTC_STATUS);
  assign sel_enable = (csr_a == BASE_ADDR + INTC_ENABLE);
  assign sel_mode   = (csr_a == BASE_ADDR + INTC_MODE);
  assign sel_raw    = (csr_a == BASE_ADDR + INTC_RAW);

  assign wdata    = csr_di[NUM_IRQS-1:0];
  assign w1c      = (csr_we && sel_status) ? wdata : '0;
  assign mode_chg = (csr_we && sel_mode) ? (wdata ^ mode) : '0;

  // A mode change discards stale state; in edge mode a new edge beats a W1C.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_IRQS; i++) begin
      if (mode_chg[i])      pending_nxt[i] = 1'b0;
      else if (!mode[i])    pending_nxt[i] = level[i];
      else if (edge_evt[i]) pending_nxt[i] = 1'b1;
      else if (w1c[i])      pending_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      irq_out <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (csr_we && sel_enable) enable <= wdata;
      if (csr_we && sel_mode)   mode   <= wdata;
      irq_out <= |(pending & enable);
    end
  end

  // Unimplemented bits read as zero.
  always_comb begin
    pend_rd = '0;
    en_rd   = '0;
    mode_rd = '0;
    raw_rd  = '0;
    pend_rd[NUM_IRQS-1:0] = pending;
    en_rd[NUM_IRQS-1:0]   = enable;
    mode_rd[NUM_IRQS-1:0] = mode;
    raw_rd[NUM_IRQS-1:0]  = level;
  end

  always_comb begin
    csr_do = 8'h00;
    if (sel_status)      csr_do = pend_rd;
    else if (sel_enable) csr_do = en_rd;
    else if (sel_mode)   csr_do = mode_rd;
    else if (sel_raw)    csr_do = raw_rd;
  end

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: an 8-source and a 4-source instance share the CSR bus.
// Expected CSR reads are queued as stimulus is driven and popped when read back.
module tb_intc;

  localparam logic [4:0] A_ST  = 5'h1c;
  localparam logic [4:0] A_EN  = 5'h1d;
  localparam logic [4:0] A_MD  = 5'h1e;
  localparam logic [4:0] A_RAW = 5'h1f;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       we8, we4;
  logic [7:0] do8, do4;
  logic [7:0] irq8;
  logic [3:0] irq4;
  logic       out8, out4;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] expv, got;

  always #5 clk = ~clk;

  intc #(.BASE_ADDR(5'h1c), .NUM_IRQS(8)) dut8 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(we8),
    .csr_do(do8), .irq_in(irq8), .irq_out(out8)
  );

  intc #(.BASE_ADDR(5'h1c), .NUM_IRQS(4)) dut4 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(we4),
    .csr_do(do4), .irq_in(irq4), .irq_out(out4)
  );

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit sel4, input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    if (sel4) we4 = 1'b1;
    else      we8 = 1'b1;
    @(negedge clk);
    we4 = 1'b0;
    we8 = 1'b0;
  endtask

  task automatic rd(input bit sel4, input logic [4:0] a, output logic [7:0] d);
    csr_a = a;
    #1;
    d = sel4 ? do4 : do8;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [5];
    addrs = '{A_ST, A_EN, A_MD, A_RAW, 5'h1b};
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 5; i++) begin
      rd(0, addrs[i], got);
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin errors++; $display("[TB] FAIL reset_read a=%h: got %h expected %h", addrs[i], got, expv); end
    end
    checks++;
    if (out8 !== 1'b0 || out4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq_out: got %b/%b expected 0/0", out8, out4); end
  endtask

  task automatic test_edge();
    wr(0, A_MD, 8'h01);
    wr(0, A_EN, 8'h01);
    irq8[0] = 1'b1;
    cycle(2);
    irq8[0] = 1'b0;
    checks++;
    if (out8 !== 1'b0) begin errors++; $display("[TB] FAIL edge_early_e1: got %b expected 0", out8); end
    cycle(1);
    exp_q.push_back(8'h01);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL edge_status: got %h expected %h", got, expv); end
    checks++;
    if (out8 !== 1'b0) begin errors++; $display("[TB] FAIL edge_early_e2: got %b expected 0", out8); end
    cycle(1);
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL edge_irq_e3: got %b expected 1", out8); end
    wr(0, A_ST, 8'h01);
    exp_q.push_back(8'h00);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL edge_w1c_status: got %h expected %h", got, expv); end
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL edge_w1c_same_edge: got %b expected 1", out8); end
    cycle(1);
    checks++;
    if (out8 !== 1'b0) begin errors++; $display("[TB] FAIL edge_ack: got %b expected 0", out8); end
  endtask

  task automatic test_level();
    wr(0, A_MD, 8'h00);
    wr(0, A_EN, 8'h02);
    irq8[1] = 1'b1;
    cycle(3);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    rd(0, A_RAW, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL level_raw: got %h expected %h", got, expv); end
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL level_status: got %h expected %h", got, expv); end
    cycle(1);
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL level_irq: got %b expected 1", out8); end
    wr(0, A_ST, 8'h02);
    exp_q.push_back(8'h02);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL level_w1c_ignored: got %h expected %h", got, expv); end
    cycle(1);
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL level_irq_after_w1c: got %b expected 1", out8); end
    irq8[1] = 1'b0;
    cycle(3);
    exp_q.push_back(8'h00);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL level_drop_status: got %h expected %h", got, expv); end
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL level_drop_early: got %b expected 1", out8); end
    cycle(1);
    checks++;
    if (out8 !== 1'b0) begin errors++; $display("[TB] FAIL level_drop_irq: got %b expected 0", out8); end
  endtask

  task automatic test_w1c_collision();
    wr(0, A_MD, 8'h04);
    wr(0, A_EN, 8'h04);
    irq8[2] = 1'b1;
    cycle(4);
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL coll_setup_irq: got %b expected 1", out8); end
    irq8[2] = 1'b0;
    cycle(3);
    irq8[2] = 1'b1;
    cycle(2);
    wr(0, A_ST, 8'h04);
    exp_q.push_back(8'h04);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL coll_status: got %h expected %h", got, expv); end
    cycle(1);
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL coll_irq_n1: got %b expected 1", out8); end
    cycle(1);
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL coll_irq_n2: got %b expected 1", out8); end
    irq8[2] = 1'b0;
    wr(0, A_ST, 8'h04);
    cycle(1);
    checks++;
    if (out8 !== 1'b0) begin errors++; $display("[TB] FAIL coll_ack: got %b expected 0", out8); end
  endtask

  task automatic test_enable_gate();
    wr(0, A_EN, 8'h00);
    wr(0, A_MD, 8'h08);
    irq8[3] = 1'b1;
    cycle(3);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h08);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL gate_status: got %h expected %h", got, expv); end
    rd(0, A_RAW, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL gate_raw: got %h expected %h", got, expv); end
    cycle(2);
    checks++;
    if (out8 !== 1'b0) begin errors++; $display("[TB] FAIL gate_masked: got %b expected 0", out8); end
    // Writes that must change nothing: wrong address, RAW, strobe low.
    wr(0, 5'h1b, 8'hff);
    wr(0, A_RAW, 8'hff);
    csr_a  = A_EN;
    csr_di = 8'hff;
    cycle(1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h08);
    rd(0, A_EN, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL gate_ignored_en: got %h expected %h", got, expv); end
    rd(0, A_RAW, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL gate_ignored_raw: got %h expected %h", got, expv); end
    wr(0, A_EN, 8'h08);
    checks++;
    if (out8 !== 1'b0) begin errors++; $display("[TB] FAIL gate_en_same_edge: got %b expected 0", out8); end
    cycle(1);
    checks++;
    if (out8 !== 1'b1) begin errors++; $display("[TB] FAIL gate_en_irq: got %b expected 1", out8); end
    wr(0, A_MD, 8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h08);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL mode_change_clear: got %h expected %h", got, expv); end
    cycle(1);
    rd(0, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL mode_change_relevel: got %h expected %h", got, expv); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] addrs [4];
    addrs = '{A_ST, A_EN, A_MD, A_RAW};
    wr(1, A_EN, 8'hff);
    wr(1, A_MD, 8'hff);
    exp_q.push_back(8'h0f);
    exp_q.push_back(8'h0f);
    rd(1, A_EN, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL n4_enable: got %h expected %h", got, expv); end
    rd(1, A_MD, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL n4_mode: got %h expected %h", got, expv); end
    irq4[0] = 1'b1;
    cycle(4);
    checks++;
    if (out4 !== 1'b1 || out8 !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_irq: got %b/%b expected 1/1", out4, out8); end
    rst = 1'b1;
    cycle(1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      rd(1, addrs[i], got);
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin errors++; $display("[TB] FAIL mid_reset_read a=%h: got %h expected %h", addrs[i], got, expv); end
    end
    checks++;
    if (out4 !== 1'b0 || out8 !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_irq: got %b/%b expected 0/0", out4, out8); end
    rst = 1'b0;
    cycle(4);
    exp_q.push_back(8'h01);
    rd(1, A_ST, got);
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin errors++; $display("[TB] FAIL post_reset_status: got %h expected %h", got, expv); end
    checks++;
    if (out4 !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_masked: got %b expected 0", out4); end
  endtask

  initial begin
    rst    = 1'b1;
    csr_a  = 5'h00;
    csr_di = 8'h00;
    we8    = 1'b0;
    we4    = 1'b0;
    irq8   = 8'h00;
    irq4   = 4'h0;
    cycle(3);
    rst = 1'b0;
    test_reset();
    test_edge();
    test_level();
    test_w1c_collision();
    test_enable_gate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
